alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the command FIFO depth in entries; legal values are powers of two, 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mark a command present on in_opcode/in_a/in_b.
REQ-005 in_ready  output  1  SHALL mark that the FIFO can accept a command.
REQ-006 in_opcode  input  4  SHALL be the command opcode, passed unmodified to the ALU.
REQ-007 in_a, in_b  input  8 each  SHALL be the command operands.
REQ-008 alu_opcode  output  4  SHALL drive the external ALU opcode (registered).
REQ-009 alu_a, alu_b  output  8 each  SHALL drive the external ALU operands (registered).
REQ-010 alu_result  input  8  SHALL be the combinational ALU result for alu_opcode/alu_a/alu_b.
REQ-011 alu_zero  input  1  SHALL be the ALU zero flag.
REQ-012 out_valid  output  1  SHALL mark a captured result on out_result/out_zero/out_seq.
REQ-013 out_ready  input  1  SHALL mark that the consumer accepts the result.
REQ-014 out_result  output  8, out_zero  output  1  SHALL be the registered result and flag.
REQ-015 out_seq  output  8  SHALL be the ordinal of the command that produced the result, modulo 256.
REQ-016 level  output  clog2(DEPTH)+1  SHALL report the FIFO occupancy.

Function
REQ-017 Commands SHALL be accepted (pushed) when in_valid and in_ready are both 1 at a rising edge; in_ready SHALL equal (level < DEPTH), with no dependence on in_valid.
REQ-018 The FIFO SHALL be first-in first-out; results SHALL emerge in acceptance order, with no drops or duplicates.
REQ-019 The FSM SHALL have states IDLE, DRIVE and RESP.
REQ-020 IDLE: when level != 0, the FSM SHALL pop the head into alu_opcode/alu_a/alu_b and go to DRIVE; otherwise it SHALL stay in IDLE.
REQ-021 DRIVE (exactly one cycle): at the next edge, the block SHALL capture alu_result/alu_zero into out_result/out_zero, load out_seq with the issue counter, increment the issue counter (8-bit wrap 255->0), and go to RESP.
REQ-022 RESP: out_valid SHALL be 1, and out_result/out_zero/out_seq SHALL be held stable until the handshake (out_valid and out_ready).
REQ-023 On that handshake, if level != 0 the FSM SHALL pop the next head and go directly to DRIVE; otherwise it SHALL go to IDLE.
REQ-024 out_valid SHALL be 1 only in RESP.
REQ-025 Latency: a command pushed into an empty FIFO while the FSM is in IDLE SHALL have out_valid=1 exactly 2 cycles after the accepting edge.
REQ-026 Sustained throughput with out_ready tied to 1 SHALL be one result per 2 cycles.
REQ-027 Simultaneous push and pop SHALL leave level unchanged.
REQ-028 A push at full SHALL be impossible (in_ready=0), and a pop at empty SHALL never occur.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; level SHALL reach DEPTH exactly.
REQ-030 alu_* outputs SHALL hold their last value outside DRIVE.

Reset
REQ-031 While rst_n=0, the block SHALL immediately, asynchronously, force:
- FSM to IDLE; level, FIFO pointers and issue counter to 0.
- alu_opcode/alu_a/alu_b, out_result, out_zero and out_seq to 0.
- out_valid to 0; in_ready to 1.
REQ-032 Reset asserted mid-operation (any state) SHALL discard all queued commands and any pending result.
REQ-033 Deassertion SHALL be synchronised in the design; the first push SHALL be accepted no earlier than the second rising edge after deassertion.

Verification
REQ-034 Single command: push op=4'h0, a=8'h05, b=8'h03 with an ALU model where op 0 is ADD -> out_valid 2 cycles later, out_result=8'h08, out_zero=0, out_seq=0.
REQ-035 Zero flag and wrap: push ADD a=8'hFF, b=8'h01 -> out_result=8'h00, out_zero=1.
REQ-036 Backpressure/full (DEPTH=4): out_ready=0, push 6 commands back-to-back -> in_ready falls after level reaches 4; exactly 5 accepted (4 queued plus 1 in RESP); then out_ready=1 -> 5 results in order, out_seq 0..4.
REQ-037 Streaming: out_ready=1 and in_valid=1 continuously for 300 commands -> a result every 2 cycles, out_seq wraps 255->0, no loss.
REQ-038 Reset mid-operation: assert rst_n=0 in RESP with level=3 -> out_valid=0, level=0 and in_ready=1 without waiting for a clock edge; no stale result after release.
REQ-039 Simultaneous push/pop at level=2 -> level stays 2, and ordering is preserved.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU and result ports of alu_op_sequencer; slave is the sequencer side.
// Handshakes are valid/ready; level reports command FIFO occupancy.
interface alu_op_sequencer_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               in_opcode;
   logic [7:0]               in_a;
   logic [7:0]               in_b;
   logic [3:0]               alu_opcode;
   logic [7:0]               alu_a;
   logic [7:0]               alu_b;
   logic [7:0]               alu_result;
   logic                     alu_zero;
   logic                     out_valid;
   logic                     out_ready;
   logic [7:0]               out_result;
   logic                     out_zero;
   logic [7:0]               out_seq;
   logic [$clog2(DEPTH):0]   level;

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, alu_result, alu_zero, out_ready,
      output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_zero,
             out_seq, level
   );

   modport master (
      output in_valid, in_opcode, in_a, in_b, alu_result, alu_zero, out_ready,
      input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_result, out_zero,
             out_seq, level
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands in a FIFO and issues them one at a time; result valid 2 cycles after a push into an idle, empty block.
// in_ready drops only when the FIFO is full; a stalled result holds the FSM in RESP while the FIFO keeps filling.
module alu_op_sequencer #(
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   alu_op_sequencer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   typedef struct packed {
      logic [3:0] opcode;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   // Assert passes straight through; release is delayed two edges so no flop sees a partial deassertion.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

   cmd_t          mem [DEPTH];
   cmd_t          in_cmd;
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          in_ready;
   logic          push;
   logic          pop;

   state_t        state;
   logic [3:0]    alu_opcode;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic          out_valid;
   logic [7:0]    out_result;
   logic          out_zero;
   logic [7:0]    out_seq;
   logic [7:0]    seq_cnt;

   assign in_cmd   = {bus.in_opcode, bus.in_a, bus.in_b};
   assign head     = mem[rd_ptr];
   assign in_ready = (level < LW'(DEPTH));
   assign push     = bus.in_valid && in_ready;
   // Pop only when the ALU stage is free: idle, or the held result is leaving this cycle.
   assign pop      = (level != '0) &&
                     ((state == IDLE) || ((state == RESP) && bus.out_ready));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_cmd;
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state      <= IDLE;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_seq    <= '0;
         seq_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  alu_opcode <= head.opcode;
                  alu_a      <= head.a;
                  alu_b      <= head.b;
                  state      <= DRIVE;
               end
            end
            DRIVE: begin
               out_result <= bus.alu_result;
               out_zero   <= bus.alu_zero;
               out_seq    <= seq_cnt;
               seq_cnt    <= seq_cnt + 8'd1;
               out_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  if (pop) begin
                     alu_opcode <= head.opcode;
                     alu_a      <= head.a;
                     alu_b      <= head.b;
                     state      <= DRIVE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.alu_opcode = alu_opcode;
   assign bus.alu_a      = alu_a;
   assign bus.alu_b      = alu_b;
   assign bus.out_valid  = out_valid;
   assign bus.out_result = out_result;
   assign bus.out_zero   = out_zero;
   assign bus.out_seq    = out_seq;
   assign bus.level      = level;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: an in-order expectation queue checks every result handshake,
// and hand-computed literals pin latency, zero flag, full behaviour, reset and sequence wrap.
module tb_alu_op_sequencer;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();
   alu_op_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] res;
      logic       zero;
      logic [7:0] seq;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_seq = 8'd0;
   logic       hold_vld = 1'b0;
   logic [7:0] hold_res;
   logic       hold_zero;
   logic [7:0] hold_seq;

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         4'h0:    return a + b;
         4'h1:    return a - b;
         4'h2:    return a & b;
         4'h3:    return a | b;
         4'h4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   assign bus.alu_result = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
   assign bus.alu_zero   = (bus.alu_result == 8'h00);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
      bus.in_valid  = v;
      bus.in_opcode = op;
      bus.in_a      = a;
      bus.in_b      = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted command appends its expected result; every handshake consumes one.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         model_seq = 8'd0;
         hold_vld  = 1'b0;
      end else begin
         if (hold_vld) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.out_result, hold_res);
            check("hold_zero", bus.out_zero, hold_zero);
            check("hold_seq", bus.out_seq, hold_seq);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_result", bus.out_result, e.res);
               check("sb_zero", bus.out_zero, e.zero);
               check("sb_seq", bus.out_seq, e.seq);
            end
         end
         hold_vld  = bus.out_valid && !bus.out_ready;
         hold_res  = bus.out_result;
         hold_zero = bus.out_zero;
         hold_seq  = bus.out_seq;
         if (bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.res  = alu_f(bus.in_opcode, bus.in_a, bus.in_b);
            e.zero = (e.res == 8'h00);
            e.seq  = model_seq;
            exp_q.push_back(e);
            model_seq = model_seq + 8'd1;
         end
         check("ready_rule", bus.in_ready, (int'(bus.level) < DEPTH));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int n;
      int lat;
      int guard;

      drive(1'b0, 4'h0, 8'h00, 8'h00);
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_level", bus.level, 0);
      check("rst_alu_a", bus.alu_a, 0);
      check("rst_out_result", bus.out_result, 0);
      check("rst_out_seq", bus.out_seq, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Single command 5+3, latency measured from the accepting edge.
      bus.out_ready = 1'b1;
      drive(1'b1, 4'h0, 8'h05, 8'h03);
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
      lat = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 10);
      check("latency", lat, 2);
      check("single_result", bus.out_result, 8'h08);
      check("single_zero", bus.out_zero, 0);
      check("single_seq", bus.out_seq, 0);

      // FF+01 wraps to zero.
      @(posedge clk);
      #1 drive(1'b1, 4'h0, 8'hFF, 8'h01);
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
      guard = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         guard++;
      end while (!bus.out_valid && guard < 10);
      check("wrap_result", bus.out_result, 8'h00);
      check("wrap_zero", bus.out_zero, 1);
      check("wrap_seq", bus.out_seq, 1);

      // Full: six commands offered one cycle each with the consumer stalled.
      do_reset();
      bus.out_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1 drive(1'b1, 4'h0, 8'd10, 8'(k));
         @(negedge clk);
         if (bus.in_ready) acc++;
      end
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
      @(negedge clk);
      check("full_accepted", acc, 5);
      check("full_level", bus.level, 4);
      check("full_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      n = 0;
      guard = 0;
      while (n < 5 && guard < 40) begin
         @(negedge clk);
         if (bus.out_valid) begin
            check("full_seq", bus.out_seq, n);
            check("full_result", bus.out_result, 10 + n);
            n++;
         end
         guard++;
         @(posedge clk);
      end
      check("full_count", n, 5);

      // Push and pop on the same edge at level 2.
      do_reset();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 drive(1'b1, 4'h4, 8'(k + 1), 8'h55);
      end
      @(posedge clk);
      #1 drive(1'b1, 4'h1, 8'h40, 8'h01);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("simul_level_before", bus.level, 2);
      check("simul_valid_before", bus.out_valid, 1);
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("simul_level_after", bus.level, 2);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("simul_drained", exp_q.size(), 0);
      check("simul_level_empty", bus.level, 0);

      // Reset in RESP with three commands queued.
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 drive(1'b1, 4'h3, 8'(k), 8'h80);
      end
      @(posedge clk);
      #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
      @(negedge clk);
      check("midrst_level_before", bus.level, 3);
      check("midrst_valid_before", bus.out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_level", bus.level, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      acc = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) acc++;
      end
      check("midrst_no_stale", acc, 0);
      check("midrst_level_after", bus.level, 0);

      // Streaming 300 commands with the consumer always ready.
      @(posedge clk);
      #1;
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               int g;
               @(posedge clk);
               #1 drive(1'b1, 4'(k % 5), 8'(k), 8'(k * 3));
               @(negedge clk);
               g = 0;
               while (!bus.in_ready && g < 20) begin
                  @(posedge clk);
                  @(negedge clk);
                  g++;
               end
            end
            @(posedge clk);
            #1 drive(1'b0, 4'h0, 8'h00, 8'h00);
         end
         begin
            int cnt;
            int cyc;
            int last;
            cnt  = 0;
            cyc  = 0;
            last = 0;
            while (cnt < 300 && cyc < 2000) begin
               @(negedge clk);
               cyc++;
               if (bus.out_valid) begin
                  if (cnt > 0) check("stream_gap", cyc - last, 2);
                  if (cnt == 255) check("stream_seq_255", bus.out_seq, 8'hFF);
                  if (cnt == 256) check("stream_seq_wrap", bus.out_seq, 8'h00);
                  last = cyc;
                  cnt++;
               end
            end
            check("stream_count", cnt, 300);
         end
      join
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("stream_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
